// File: rtl/riscv_zero_hazard_ctrl.sv
// Decode-stage sequencing: register scoreboard for RAW/structural stalls,
// redirect flush window after taken branches, and a stall-cycle counter.
module riscv_zero_hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic [4:0]          dec_rd,
  input  logic                dec_wb_en,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                redirect_valid,
  output logic                stall,
  output logic                issue,
  output logic                flush_decode,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic                sb_error,
  output logic [31:0]         stall_cycles
);

  localparam int              IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t state_reg, state_next;
  logic [3:0] fcnt_reg, fcnt_next;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_reg, cnt_next;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic raw_hazard, struct_hazard, flush_raw;
  logic inc, dec, wb_orphan;

  // x0 and any address beyond the tracked range read as "never pending"
  function automatic logic tracked(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NUM_REGS);
  endfunction

  assign cnt_rs1 = tracked(dec_rs1) ? cnt_reg[dec_rs1[IDX_W-1:0]] : '0;
  assign cnt_rs2 = tracked(dec_rs2) ? cnt_reg[dec_rs2[IDX_W-1:0]] : '0;
  assign cnt_rd  = tracked(dec_rd)  ? cnt_reg[dec_rd[IDX_W-1:0]]  : '0;
  assign cnt_wb  = tracked(wb_rd)   ? cnt_reg[wb_rd[IDX_W-1:0]]   : '0;

  // Registered counts only: a same-cycle writeback still leaves the old value in the regfile read
  assign raw_hazard    = (dec_use_rs1 && (cnt_rs1 != '0)) || (dec_use_rs2 && (cnt_rs2 != '0));
  assign struct_hazard = dec_wb_en && (cnt_rd == CNT_MAX) && tracked(dec_rd);

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    flush_raw  = 1'b0;
    case (state_reg)
      ST_RUN: begin
        flush_raw = redirect_valid;
        if (redirect_valid && (FLUSH_CYCLES > 1)) begin
          state_next = ST_FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        flush_raw = 1'b1;
        if (redirect_valid) begin
          fcnt_next = FLUSH_LOAD;
        end else if (fcnt_reg <= 4'd1) begin
          state_next = ST_RUN;
          fcnt_next  = 4'd0;
        end else begin
          fcnt_next = fcnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = ST_RUN;
        fcnt_next  = 4'd0;
      end
    endcase
  end

  assign flush_decode = !reset && flush_raw;
  assign stall        = !reset && dec_valid && (raw_hazard || struct_hazard) && !flush_raw;
  assign issue        = !reset && dec_valid && !(raw_hazard || struct_hazard) && !flush_raw;

  assign inc       = issue && dec_wb_en && tracked(dec_rd);
  assign dec       = wb_valid && (cnt_wb != '0);
  assign wb_orphan = wb_valid && (wb_rd != 5'd0) && (cnt_wb == '0);

  assign cnt_next[0] = '0;
  assign sb_busy[0]  = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic inc_hit, dec_hit;
      assign inc_hit = inc && (dec_rd == 5'(gi));
      assign dec_hit = dec && (wb_rd == 5'(gi));
      assign cnt_next[gi] = (inc_hit == dec_hit) ? cnt_reg[gi] :
                            inc_hit ? cnt_reg[gi] + 1'b1 : cnt_reg[gi] - 1'b1;
      assign sb_busy[gi]  = !reset && (cnt_reg[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      fcnt_reg     <= 4'd0;
      cnt_reg      <= '0;
      sb_error     <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      cnt_reg   <= cnt_next;
      if (wb_orphan) sb_error <= 1'b1;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_riscv_zero_hazard_ctrl.sv
// Directed bench for riscv_zero_hazard_ctrl: scoreboard stalls, flush window, errors, reset.
module tb_riscv_zero_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wb_en;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        wb_valid, redirect_valid;
  logic        stall, issue, flush_decode, sb_error;
  logic [31:0] sb_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  riscv_zero_hazard_ctrl #(.NUM_REGS(32), .CNT_W(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wb_en(dec_wb_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect_valid(redirect_valid),
    .stall(stall), .issue(issue), .flush_decode(flush_decode),
    .sb_busy(sb_busy), .sb_error(sb_error), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wb_en = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    wb_valid = 0; wb_rd = 0; redirect_valid = 0;
  endtask

  task automatic writer(input logic [4:0] rd);
    idle(); dec_valid = 1; dec_wb_en = 1; dec_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    dec_valid = 1; dec_wb_en = 1; dec_rd = 5'd3; redirect_valid = 1;
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %0b expected 0", issue); end
    checks++; if (flush_decode !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", flush_decode); end
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", sb_busy); end
    checks++; if (sb_error !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_regs: err=%0b cyc=%0d expected 0/0", sb_error, stall_cycles); end
    step(); step();
    reset = 0; idle();
    #1;
    checks++; if (flush_decode !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_release: flush=%0b stall=%0b expected 0/0", flush_decode, stall); end
    $display("reset released");
  endtask

  task automatic test_raw();
    writer(5'd5); #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_producer_issue: got %0b expected 1", issue); end
    step();
    idle(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd5; dec_use_rs2 = 1; dec_rs2 = 5'd1;
    dec_wb_en = 1; dec_rd = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL raw_stall[%0d]: stall=%0b issue=%0b expected 1/0", i, stall, issue); end
      exp_stall++;
      step();
    end
    wb_valid = 1; wb_rd = 5'd5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_same_cycle_wb: stall=%0b expected 1", stall); end
    exp_stall++;
    step();
    wb_valid = 0; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL raw_release: stall=%0b issue=%0b expected 0/1", stall, issue); end
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL raw_stall_count: got %0d expected %0d", stall_cycles, exp_stall); end
    step();
    idle(); wb_valid = 1; wb_rd = 5'd6;
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL raw_drain: busy=%h expected 0", sb_busy); end
    $display("raw stall scenario done, stalls=%0d", exp_stall);
  endtask

  task automatic test_same_cycle();
    writer(5'd7); step();
    writer(5'd7); wb_valid = 1; wb_rd = 5'd7; #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL same_issue: got %0b expected 1", issue); end
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0000_0080) begin errors++; $display("FAIL same_busy7: busy=%h expected 00000080", sb_busy); end
    writer(5'd8); wb_valid = 1; wb_rd = 5'd7;
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0000_0100) begin errors++; $display("FAIL indep_busy: busy=%h expected 00000100", sb_busy); end
    wb_valid = 1; wb_rd = 5'd8;
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL same_drain: busy=%h expected 0", sb_busy); end
    $display("same-cycle inc/dec scenario done");
  endtask

  task automatic test_redirect();
    writer(5'd10); step();
    idle(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd10; dec_wb_en = 1; dec_rd = 5'd11;
    redirect_valid = 1; #1;
    checks++; if (flush_decode !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL redir_c1: f=%0b s=%0b i=%0b expected 1/0/0", flush_decode, stall, issue); end
    step(); redirect_valid = 0; #1;
    checks++; if (flush_decode !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL redir_c2: f=%0b s=%0b i=%0b expected 1/0/0", flush_decode, stall, issue); end
    step(); #1;
    checks++; if (flush_decode !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL redir_end: f=%0b s=%0b expected 0/1", flush_decode, stall); end
    exp_stall++;
    step(); redirect_valid = 1; #1;
    checks++; if (flush_decode !== 1'b1) begin errors++; $display("FAIL redir2_c1: f=%0b expected 1", flush_decode); end
    step(); #1;
    checks++; if (flush_decode !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL redir2_c2: f=%0b s=%0b expected 1/0", flush_decode, stall); end
    step(); redirect_valid = 0; #1;
    checks++; if (flush_decode !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL redir2_extend: f=%0b i=%0b expected 1/0", flush_decode, issue); end
    step(); #1;
    checks++; if (flush_decode !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL redir2_end: f=%0b s=%0b expected 0/1", flush_decode, stall); end
    checks++; if (sb_busy !== 32'h0000_0400) begin errors++; $display("FAIL redir_no_inc: busy=%h expected 00000400", sb_busy); end
    exp_stall++;
    step();
    idle(); wb_valid = 1; wb_rd = 5'd10;
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL redir_drain: busy=%h expected 0", sb_busy); end
    $display("redirect flush scenario done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      writer(5'd9); #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_issue[%0d]: got %0b expected 1", i, issue); end
      step();
    end
    #1;
    checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL sat_struct: s=%0b i=%0b expected 1/0", stall, issue); end
    exp_stall++;
    step();
    wb_valid = 1; wb_rd = 5'd9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_same_wb: s=%0b expected 1", stall); end
    exp_stall++;
    step();
    wb_valid = 0; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL sat_release: s=%0b i=%0b expected 0/1", stall, issue); end
    step();
    idle(); wb_valid = 1; wb_rd = 5'd9;
    step(); step(); #1;
    checks++; if (sb_busy !== 32'h0000_0200) begin errors++; $display("FAIL sat_partial: busy=%h expected 00000200", sb_busy); end
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL sat_drain: busy=%h expected 0", sb_busy); end
    $display("saturation scenario done");
  endtask

  task automatic test_errors_x0();
    idle(); wb_valid = 1; wb_rd = 5'd12; #1;
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL err_pre: got %0b expected 0", sb_error); end
    step(); idle(); #1;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_set: got %0b expected 1", sb_error); end
    step(); step(); #1;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", sb_error); end
    writer(5'd0); dec_use_rs1 = 1; dec_use_rs2 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL x0_issue[%0d]: i=%0b s=%0b expected 1/0", i, issue, stall); end
      step();
    end
    idle(); #1;
    checks++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL x0_busy: busy=%h expected 0", sb_busy); end
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL stall_total: got %0d expected %0d", stall_cycles, exp_stall); end
    $display("error/x0 scenario done");
  endtask

  task automatic test_reset_mid();
    writer(5'd5); step();
    idle(); redirect_valid = 1; step();
    idle(); dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd5; dec_wb_en = 1; dec_rd = 5'd6;
    redirect_valid = 1; #1;
    checks++; if (flush_decode !== 1'b1) begin errors++; $display("FAIL rmid_pre_flush: got %0b expected 1", flush_decode); end
    reset = 1; #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b0 || flush_decode !== 1'b0) begin errors++; $display("FAIL rmid_outs: s=%0b i=%0b f=%0b expected 0/0/0", stall, issue, flush_decode); end
    checks++; if (sb_busy !== 32'h0 || sb_error !== 1'b0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL rmid_regs: busy=%h err=%0b cyc=%0d expected 0", sb_busy, sb_error, stall_cycles); end
    step();
    reset = 0; redirect_valid = 0; #1;
    checks++; if (flush_decode !== 1'b0 || issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rmid_run: f=%0b i=%0b s=%0b expected 0/1/0", flush_decode, issue, stall); end
    step(); idle(); #1;
    checks++; if (sb_busy !== 32'h0000_0040) begin errors++; $display("FAIL rmid_issue: busy=%h expected 00000040", sb_busy); end
    $display("mid-run reset scenario done");
  endtask

  initial begin
    test_reset();
    test_raw();
    test_same_cycle();
    test_redirect();
    test_back_to_back();
    test_errors_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
